instr_mem_ctrl: RTL

Controller for the byte-addressable instruction memory. It owns the instruction byte array and shares it between two users: a byte-stream program loader and the core's fetch port. At power-up it holds the core stalled until a program has been loaded. It then serves little-endian 32-bit instruction fetches with one-cycle latency. It sits between the boot/debug link and the core's PC/fetch stage.

---
 rtl/instr_mem_ctrl_pkg.sv | 16 +
 rtl/imem_byte_array.sv | 34 +++
 rtl/instr_mem_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// rtl/instr_mem_ctrl_pkg.sv - shared types and constants for the instruction memory controller
package instr_mem_ctrl_pkg;

    // Controller states: waiting for first program, loading bytes, serving fetches
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } imem_state_t;

    // Word returned on a faulting fetch (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int DEF_MEM_BYTES = 100;

endpackage

// File: rtl/imem_byte_array.sv
// rtl/imem_byte_array.sv - byte array with one write port and a 32-bit little-endian read
module imem_byte_array #(
    parameter int MEM_BYTES = 100,
    parameter int IDX_W     = $clog2(MEM_BYTES)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(MEM_BYTES - 4);

    logic [7:0] mem [MEM_BYTES];

    // Byte write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Word read; an address past the last full word reads zero rather than indexing off the end
    always_comb begin
        rdata = 32'h0;
        if (raddr <= LAST_WORD) begin
            rdata = {mem[raddr + IDX_W'(3)], mem[raddr + IDX_W'(2)],
                     mem[raddr + IDX_W'(1)], mem[raddr]};
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - program loader and fetch port sharing one instruction byte array
module instr_mem_ctrl
    import instr_mem_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              load_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] PC,
    output logic              fetch_valid,
    output logic [31:0]       Instructioncode,
    output logic              fetch_err,
    output logic              core_stall
);

    localparam int                IDX_W      = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_FETCH = ADDR_W'(MEM_BYTES - 4);

    imem_state_t       state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] tgt;
    logic              tgt_ok;
    logic              len_zero;
    logic              take;
    logic              last;
    logic              wr_en;
    logic              fetch_ok;
    logic [IDX_W-1:0]  rd_addr;
    logic [31:0]       rd_data;

    // Handshake, stall and address/range decode
    always_comb begin
        ld_ready   = (state == ST_LOAD);
        core_stall = (state != ST_RUN);
        tgt        = base + cnt;
        tgt_ok     = (tgt < MEM_LIMIT);
        len_zero   = (len == '0);
        take       = ld_ready && ld_valid && !len_zero;
        last       = take && ((cnt + ADDR_W'(1)) == len);
        wr_en      = take && tgt_ok;
        fetch_ok   = (PC[1:0] == 2'b00) && (PC <= LAST_FETCH);
        rd_addr    = fetch_ok ? PC[IDX_W-1:0] : '0;
    end

    imem_byte_array #(
        .MEM_BYTES (MEM_BYTES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tgt[IDX_W-1:0]),
        .wdata (ld_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Load FSM: latch load parameters, count accepted bytes, flag out-of-range targets
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            base     <= '0;
            len      <= '0;
            cnt      <= '0;
            load_err <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (ld_start) begin
                        state    <= ST_LOAD;
                        base     <= ld_base;
                        len      <= ld_len;
                        cnt      <= '0;
                        load_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (take) begin
                        cnt <= cnt + ADDR_W'(1);
                        if (!tgt_ok) begin
                            load_err <= 1'b1;
                        end
                    end
                    if (len_zero || last) begin
                        state   <= ST_RUN;
                        ld_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Fetch register: one response per request in RUN, a new load takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_valid     <= 1'b0;
            fetch_err       <= 1'b0;
            Instructioncode <= 32'h0;
        end else begin
            fetch_valid <= 1'b0;
            if ((state == ST_RUN) && fetch_req && !ld_start) begin
                fetch_valid     <= 1'b1;
                fetch_err       <= !fetch_ok;
                Instructioncode <= fetch_ok ? rd_data : NOP_INSTR;
            end
        end
    end

endmodule
